bcd_serial_addsub: RTL and testbench

//   Multi-digit packed-BCD adder/subtractor, digit-serial: one decimal digit per clock, LSD first.

---
 rtl/bcd_serial_addsub.sv | 110 +++++++++++
 tb/tb_bcd_serial_addsub.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, least significant first.
// A single 4-bit add + decimal-correct slice is reused across DIGITS cycles.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                c_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] s,
  output logic                c_out,
  output logic                err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, s_q;
  logic [CntW-1:0] cnt_q;
  logic            sub_q, carry_q, err_acc_q;
  logic            c_out_q, err_q, out_valid_q, in_ready_q;

  logic [3:0] a_dig, b_raw, b_dig, s_dig;
  logic [4:0] t;
  logic       k, dig_bad;

  // B is kept raw so the invalid-digit check sees the original digit; 9's complement is
  // applied in the slice, which is equivalent to complementing at accept.
  always_comb begin
    a_dig   = a_q[3:0];
    b_raw   = b_q[3:0];
    b_dig   = sub_q ? (4'd9 - b_raw) : b_raw;
    t       = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
    k       = t[4] | (t[3] & t[2]) | (t[3] & t[1]);
    s_dig   = k ? (t[3:0] + 4'd6) : t[3:0];
    dig_bad = (a_dig > 4'd9) | (b_raw > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      err_acc_q   <= 1'b0;
      c_out_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            sub_q      <= sub;
            carry_q    <= sub ? 1'b1 : c_in;
            err_acc_q  <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          a_q       <= a_q >> 4;
          b_q       <= b_q >> 4;
          // New digit enters at the top; after DIGITS shifts digit 0 sits at s[3:0].
          s_q       <= W'({s_dig, s_q} >> 4);
          carry_q   <= k;
          err_acc_q <= err_acc_q | dig_bad;
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            c_out_q     <= k;
            err_q       <= err_acc_q | dig_bad;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomised + directed bench for bcd_serial_addsub against an integer-arithmetic BCD model.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         c_out;
  logic         err;

  int checks = 0;
  int errors = 0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 15) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // One full operation: accept, latency, result, optional stalled HOLD, handshake.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic cv, input int hold);
    longint       m, r;
    logic [W-1:0] exp_s;
    logic         exp_c, exp_e;
    int           lat;
    bit           done;
    m     = pow10(DIGITS);
    r     = sv ? bcd2int(av) + (m - 1 - bcd2int(bv)) + 1 : bcd2int(av) + bcd2int(bv) + cv;
    exp_s = int2bcd(r % m);
    exp_c = (r >= m);
    exp_e = has_bad(av) | has_bad(bv);

    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = av; b = bv; sub = sv; c_in = cv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rand_bcd(1); b = rand_bcd(1); sub = 1'($urandom); c_in = 1'($urandom);
    check("in_ready_run", in_ready, 0);
    lat = 0; done = 0;
    for (int i = 0; i < 4 * DIGITS + 4 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) done = 1;
    end
    check("latency", lat, DIGITS);
    if (!exp_e) begin
      check("s", s, exp_s);
      check("c_out", c_out, exp_c);
    end
    check("err", err, exp_e);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = rand_bcd(0); b = rand_bcd(0);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      if (!exp_e) check("hold_s", s, exp_s);
      if (!exp_e) check("hold_c_out", c_out, exp_c);
      check("hold_err", err, exp_e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_c_out", c_out, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 0);
    run_op(16'h0042, 16'h0042, 1'b1, 1'b0, 0);
    run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    check("after_err_s", s, 16'h0002);
    run_op(16'h0507, 16'h0608, 1'b0, 1'b1, 3);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_s", s, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 2 * DIGITS; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1;
      end
      check("midrst_no_valid", seen, 0);
    end
    run_op(16'h2468, 16'h1357, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(rand_bcd(1), rand_bcd(1), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
